// File: rtl/boot_rom_arbiter_if.sv
// Bus bundle between the two boot ROM masters, the arbiter and the ROM port.
// The arbiter connects through the slave modport; the environment uses master.
interface boot_rom_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]                 m_req_i;
    logic [1:0][ADDR_WIDTH-1:0] m_add_i;
    logic [1:0]                 m_wen_i;
    logic [1:0]                 m_gnt_o;
    logic [1:0]                 m_r_valid_o;
    logic [DATA_WIDTH-1:0]      m_r_rdata_o;
    logic                       s_req_o;
    logic [ADDR_WIDTH-1:0]      s_add_o;
    logic                       s_gnt_i;
    logic [DATA_WIDTH-1:0]      s_r_rdata_i;
    logic                       wr_err_o;

    modport slave (
        input  m_req_i, m_add_i, m_wen_i, s_gnt_i, s_r_rdata_i,
        output m_gnt_o, m_r_valid_o, m_r_rdata_o, s_req_o, s_add_o, wr_err_o
    );

    modport master (
        output m_req_i, m_add_i, m_wen_i, s_gnt_i, s_r_rdata_i,
        input  m_gnt_o, m_r_valid_o, m_r_rdata_o, s_req_o, s_add_o, wr_err_o
    );
endinterface

// File: rtl/boot_rom_arbiter.sv
// Two-master round-robin arbiter in front of the boot ROM; writes are absorbed and flagged.
// Define BOOT_ROM_ARB_FIXED_PRIO_EN to make master 0 always win on conflict.
module boot_rom_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    boot_rom_arbiter_if.slave bus
);
    logic                  prio;
    logic                  winner;
    logic                  any_req;
    logic                  win_write;
    logic                  grant;
    logic                  resp_reg;
    logic                  resp_sel_reg;
    logic                  resp_wr_reg;
    logic                  wr_err_reg;
    logic [ADDR_WIDTH-1:0] win_add;
    logic [DATA_WIDTH-1:0] rdata_mux;

    always_comb begin
        any_req   = |bus.m_req_i;
        winner    = (bus.m_req_i[0] & bus.m_req_i[1]) ? prio : bus.m_req_i[1];
        win_write = ~bus.m_wen_i[winner];
        win_add   = bus.m_add_i[winner];
        // Writes complete locally, so they never wait for the ROM grant.
        grant     = any_req & (win_write | bus.s_gnt_i);
        rdata_mux = resp_wr_reg ? '0 : bus.s_r_rdata_i;
    end

    assign bus.s_req_o     = any_req & ~win_write;
    assign bus.s_add_o     = win_add;
    assign bus.m_r_rdata_o = rdata_mux;
    assign bus.wr_err_o    = wr_err_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign bus.m_gnt_o[gi]     = grant & (winner == 1'(gi));
            assign bus.m_r_valid_o[gi] = resp_reg & (resp_sel_reg == 1'(gi));
        end
    endgenerate

`ifdef BOOT_ROM_ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    logic prio_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_reg <= 1'b0;
        end else if (grant) begin
            prio_reg <= ~winner;
        end
    end

    assign prio = prio_reg;
`endif

    // Response state: one registered slot, refilled on every grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_reg     <= 1'b0;
            resp_sel_reg <= 1'b0;
            resp_wr_reg  <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            resp_reg <= grant;
            if (grant) begin
                resp_sel_reg <= winner;
                resp_wr_reg  <= win_write;
                if (win_write) begin
                    wr_err_reg <= 1'b1;
                end
            end
        end
    end
endmodule
